// File: rtl/l1_beam_trigger_ctrl_pkg.sv
// Shared widths, reset constants and types for the L1 beam trigger control path.
// The threshold array type is also used by beamform_trigger.
package l1_trigger_pkg;
  localparam int NBEAMS_DEF       = 2;
  localparam int THRESH_BITS_DEF  = 18;
  localparam int HOLDOFF_BITS_DEF = 8;
  localparam int SCALER_BITS_DEF  = 16;
  localparam int GATE_BITS_DEF    = 24;

  localparam logic [THRESH_BITS_DEF-1:0] THRESH_RESET = '1;

  typedef logic [NBEAMS_DEF-1:0][THRESH_BITS_DEF-1:0] thresh_arr_t;

  // Select width for a beam index; one bit minimum so a single beam still has a port.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/l1_beam_trigger_ctrl_if.sv
// Bus between the trigger control stage and its surroundings (threshold write,
// raw comparator hits, trigger outputs, scaler readout).
interface l1_beam_trigger_ctrl_if #(
  parameter int NBEAMS       = l1_trigger_pkg::NBEAMS_DEF,
  parameter int THRESH_BITS  = l1_trigger_pkg::THRESH_BITS_DEF,
  parameter int HOLDOFF_BITS = l1_trigger_pkg::HOLDOFF_BITS_DEF,
  parameter int SCALER_BITS  = l1_trigger_pkg::SCALER_BITS_DEF,
  parameter int GATE_BITS    = l1_trigger_pkg::GATE_BITS_DEF
);
  import l1_trigger_pkg::*;
  localparam int SEL_BITS = sel_bits(NBEAMS);

  logic [THRESH_BITS-1:0]             thresh_i;
  logic [NBEAMS-1:0]                  thresh_ce_i;
  logic                               update_i;
  logic [NBEAMS-1:0][THRESH_BITS-1:0] thresh_o;
  logic [NBEAMS-1:0]                  beam_trig_i;
  logic [NBEAMS-1:0]                  mask_i;
  logic [HOLDOFF_BITS-1:0]            holdoff_i;
  logic [GATE_BITS-1:0]               gate_len_i;
  logic [NBEAMS-1:0]                  trigger_o;
  logic                               trig_any_o;
  logic [SEL_BITS-1:0]                scal_sel_i;
  logic [SCALER_BITS-1:0]             scal_dat_o;
  logic                               scal_valid_o;

  modport master (
    output thresh_i, thresh_ce_i, update_i, beam_trig_i, mask_i, holdoff_i,
           gate_len_i, scal_sel_i,
    input  thresh_o, trigger_o, trig_any_o, scal_dat_o, scal_valid_o
  );
  modport slave (
    input  thresh_i, thresh_ce_i, update_i, beam_trig_i, mask_i, holdoff_i,
           gate_len_i, scal_sel_i,
    output thresh_o, trigger_o, trig_any_o, scal_dat_o, scal_valid_o
  );
endinterface

// File: rtl/l1_beam_trigger_ctrl_holdoff.sv
// One beam: accept/holdoff logic, registered trigger pulse and a saturating
// scaler that is latched and cleared at the gate terminal cycle.
module l1_beam_holdoff #(
  parameter int HOLDOFF_BITS = 8,
  parameter int SCALER_BITS  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    trig,
  input  logic                    mask,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic                    gate_end,
  input  logic                    latch,
  output logic                    trig_nx,
  output logic                    trig_q,
  output logic [SCALER_BITS-1:0]  latched
);
  logic [HOLDOFF_BITS-1:0] hold;
  logic [SCALER_BITS-1:0]  cnt, cnt_nx;

  always_comb begin
    trig_nx = trig && !mask && (hold == '0);
    cnt_nx  = cnt;
    if (trig_nx && !(&cnt)) cnt_nx = cnt + SCALER_BITS'(1);
  end

  // The latch takes cnt_nx so an accept in the terminal cycle lands in the closing gate.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hold    <= '0;
      trig_q  <= 1'b0;
      cnt     <= '0;
      latched <= '0;
    end else begin
      trig_q <= trig_nx;
      if (trig_nx)          hold <= holdoff;
      else if (hold != '0)  hold <= hold - HOLDOFF_BITS'(1);
      if (latch)            latched <= cnt_nx;
      cnt <= gate_end ? '0 : cnt_nx;
    end
  end
endmodule

// File: rtl/l1_beam_trigger_ctrl.sv
// L1 per-beam trigger control: double-buffered thresholds, per-beam holdoff
// and masking, trigger OR, and gated per-beam rate scalers.
module l1_beam_trigger_ctrl #(
  parameter int NBEAMS       = l1_trigger_pkg::NBEAMS_DEF,
  parameter int THRESH_BITS  = l1_trigger_pkg::THRESH_BITS_DEF,
  parameter int HOLDOFF_BITS = l1_trigger_pkg::HOLDOFF_BITS_DEF,
  parameter int SCALER_BITS  = l1_trigger_pkg::SCALER_BITS_DEF,
  parameter int GATE_BITS    = l1_trigger_pkg::GATE_BITS_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  l1_beam_trigger_ctrl_if.slave bus
);
  import l1_trigger_pkg::*;
  localparam int SEL_BITS = sel_bits(NBEAMS);

  logic [NBEAMS-1:0][THRESH_BITS-1:0] pending, active;

  // Update copies the pre-edge pending value, so a same-cycle write waits for the next update.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pending <= '1;
      active  <= '1;
    end else begin
      if (bus.update_i) active <= pending;
      for (int b = 0; b < NBEAMS; b++)
        if (bus.thresh_ce_i[b]) pending[b] <= bus.thresh_i;
    end
  end

  assign bus.thresh_o = active;

  logic [GATE_BITS-1:0] gate_cnt, gate_len_q, gate_len_eff;
  logic                 gate_end;

  // Gate length is taken live in the first cycle of a period and held for the rest.
  always_comb begin
    gate_len_eff = (gate_cnt == '0) ? bus.gate_len_i : gate_len_q;
    gate_end     = (gate_cnt == gate_len_eff);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      gate_cnt   <= '0;
      gate_len_q <= '0;
    end else begin
      if (gate_cnt == '0) gate_len_q <= bus.gate_len_i;
      gate_cnt <= gate_end ? '0 : gate_cnt + GATE_BITS'(1);
    end
  end

  logic [NBEAMS-1:0]                  trig_nx, trig_q;
  logic [NBEAMS-1:0][SCALER_BITS-1:0] latched;

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    l1_beam_holdoff #(
      .HOLDOFF_BITS(HOLDOFF_BITS),
      .SCALER_BITS (SCALER_BITS)
    ) u_beam (
      .aclk    (aclk),
      .aresetn (aresetn),
      .trig    (bus.beam_trig_i[b]),
      .mask    (bus.mask_i[b]),
      .holdoff (bus.holdoff_i),
      .gate_end(gate_end),
      .latch   (gate_end),
      .trig_nx (trig_nx[b]),
      .trig_q  (trig_q[b]),
      .latched (latched[b])
    );
  end

  logic                   trig_any, scal_valid;
  logic [SCALER_BITS-1:0] scal_dat;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      trig_any   <= 1'b0;
      scal_valid <= 1'b0;
      scal_dat   <= '0;
    end else begin
      trig_any   <= |trig_nx;
      scal_valid <= gate_end;
      scal_dat   <= (int'(bus.scal_sel_i) < NBEAMS) ? latched[bus.scal_sel_i] : '0;
    end
  end

  assign bus.trigger_o    = trig_q;
  assign bus.trig_any_o   = trig_any;
  assign bus.scal_valid_o = scal_valid;
  assign bus.scal_dat_o   = scal_dat;

  logic unused_sel_w;
  assign unused_sel_w = ^SEL_BITS'(0);
endmodule

// File: tb/tb_l1_beam_trigger_ctrl.sv
// Bench for l1_beam_trigger_ctrl: threshold shadowing, holdoff/mask vectors
// through a scoreboard, scaler gate timing, saturation and mid-gate reset.
module tb_l1_beam_trigger_ctrl;
  localparam int NB = 2, TW = 18, HB = 8, SB = 4, GB = 24;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  l1_beam_trigger_ctrl_if #(.NBEAMS(NB), .THRESH_BITS(TW), .HOLDOFF_BITS(HB),
                            .SCALER_BITS(SB), .GATE_BITS(GB)) bus();

  l1_beam_trigger_ctrl #(.NBEAMS(NB), .THRESH_BITS(TW), .HOLDOFF_BITS(HB),
                         .SCALER_BITS(SB), .GATE_BITS(GB)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] trig;
    logic [1:0] mask;
    logic [7:0] ho;
    logic [1:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0] trig;
    logic       any;
  } exp_t;

  vec_t vecs[31];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.scal_valid_o && n < limit);
  endtask

  task automatic set_vec(input int i, input logic [1:0] t, input logic [1:0] m,
                         input logic [7:0] h, input logic [1:0] e);
    vecs[i] = '{trig: t, mask: m, ho: h, exp: e};
  endtask

  initial begin
    int   n, seen;
    exp_t e;

    // holdoff 3 on a steady beam 0: accepts at 0, 4, 8
    for (int i = 0; i < 10; i++) set_vec(i, 2'b01, 2'b00, 8'd3, (i % 4 == 0) ? 2'b01 : 2'b00);
    for (int i = 10; i < 14; i++) set_vec(i, 2'b00, 2'b00, 8'd0, 2'b00);
    // mask on beam 1, then release
    set_vec(14, 2'b10, 2'b10, 8'd0, 2'b00);
    set_vec(15, 2'b10, 2'b10, 8'd0, 2'b00);
    set_vec(16, 2'b10, 2'b00, 8'd0, 2'b10);
    set_vec(17, 2'b11, 2'b00, 8'd0, 2'b11);
    set_vec(18, 2'b11, 2'b01, 8'd0, 2'b10);
    set_vec(19, 2'b00, 2'b00, 8'd0, 2'b00);
    // holdoff sampled only at accept
    set_vec(20, 2'b01, 2'b00, 8'd2, 2'b01);
    set_vec(21, 2'b01, 2'b00, 8'd0, 2'b00);
    set_vec(22, 2'b01, 2'b00, 8'd0, 2'b00);
    set_vec(23, 2'b01, 2'b00, 8'd0, 2'b01);
    set_vec(24, 2'b00, 2'b00, 8'd0, 2'b00);
    // masking during holdoff keeps the hold counter running
    set_vec(25, 2'b01, 2'b00, 8'd3, 2'b01);
    set_vec(26, 2'b01, 2'b01, 8'd0, 2'b00);
    set_vec(27, 2'b01, 2'b00, 8'd0, 2'b00);
    set_vec(28, 2'b01, 2'b00, 8'd0, 2'b00);
    set_vec(29, 2'b01, 2'b00, 8'd0, 2'b01);
    set_vec(30, 2'b00, 2'b00, 8'd0, 2'b00);

    bus.thresh_i    = '0;
    bus.thresh_ce_i = '0;
    bus.update_i    = 1'b0;
    bus.beam_trig_i = '0;
    bus.mask_i      = '0;
    bus.holdoff_i   = '0;
    bus.gate_len_i  = 24'd1000;
    bus.scal_sel_i  = '0;

    step(3);
    check("reset thresh_o", 64'(bus.thresh_o), 64'h0000_000F_FFFF_FFFF);
    check("reset trigger_o", 64'(bus.trigger_o), 0);
    check("reset trig_any_o", 64'(bus.trig_any_o), 0);
    check("reset scal_valid_o", 64'(bus.scal_valid_o), 0);
    check("reset scal_dat_o", 64'(bus.scal_dat_o), 0);

    aresetn = 1'b1;
    bus.thresh_i = 18'd1000; bus.thresh_ce_i = 2'b01;
    step();
    bus.thresh_ce_i = '0;
    check("thresh0 before update", 64'(bus.thresh_o[0]), 64'h3FFFF);
    bus.update_i = 1'b1;
    step();
    bus.update_i = 1'b0;
    check("thresh0 after update", 64'(bus.thresh_o[0]), 1000);
    check("thresh1 untouched", 64'(bus.thresh_o[1]), 64'h3FFFF);

    bus.thresh_i = 18'd300; bus.thresh_ce_i = 2'b10;
    step();
    bus.thresh_i = 18'd500; bus.update_i = 1'b1;
    step();
    bus.thresh_ce_i = '0; bus.update_i = 1'b0;
    check("thresh1 same-cycle old", 64'(bus.thresh_o[1]), 300);
    check("thresh0 reloaded", 64'(bus.thresh_o[0]), 1000);
    bus.update_i = 1'b1;
    step();
    bus.update_i = 1'b0;
    check("thresh1 later update", 64'(bus.thresh_o[1]), 500);

    for (int i = 0; i < 31; i++) begin
      bus.beam_trig_i = vecs[i].trig;
      bus.mask_i      = vecs[i].mask;
      bus.holdoff_i   = vecs[i].ho;
      sb_q.push_back('{trig: vecs[i].exp, any: |vecs[i].exp});
      step();
      e = sb_q.pop_front();
      check($sformatf("vec%0d trigger_o", i), 64'(bus.trigger_o), 64'(e.trig));
      check($sformatf("vec%0d trig_any_o", i), 64'(bus.trig_any_o), 64'(e.any));
    end
    bus.beam_trig_i = '0; bus.mask_i = '0; bus.holdoff_i = '0;

    // first gate (length 1001) closes with beam0=8, beam1=3 accepts
    wait_valid(1200, n);
    check("gate1000 scal_valid seen", 64'(bus.scal_valid_o), 1);
    bus.scal_sel_i = 1'b0;
    step();
    check("gate1000 scal_valid one cycle", 64'(bus.scal_valid_o), 0);
    check("gate1000 beam0 scaler", 64'(bus.scal_dat_o), 8);
    bus.scal_sel_i = 1'b1;
    step();
    check("gate1000 beam1 scaler", 64'(bus.scal_dat_o), 3);

    // saturating scaler, gate_len 99, beam 0 firing every cycle
    aresetn = 1'b0;
    bus.gate_len_i = 24'd99; bus.holdoff_i = '0; bus.beam_trig_i = 2'b01;
    bus.scal_sel_i = 1'b0;
    step(2);
    check("reset2 scal_dat_o", 64'(bus.scal_dat_o), 0);
    aresetn = 1'b1;
    wait_valid(200, n);
    check("first valid latency", 64'(n), 100);
    step();
    check("sat scal_valid drops", 64'(bus.scal_valid_o), 0);
    check("sat beam0 scaler", 64'(bus.scal_dat_o), 15);
    wait_valid(200, n);
    check("valid period", 64'(n), 99);
    bus.scal_sel_i = 1'b1;
    step();
    check("sat beam1 scaler", 64'(bus.scal_dat_o), 0);
    step(48);
    check("firing before reset", 64'(bus.trigger_o), 64'b01);

    // reset mid-gate discards partial counts
    aresetn = 1'b0;
    bus.scal_sel_i = 1'b0;
    step();
    check("midreset trigger_o", 64'(bus.trigger_o), 0);
    check("midreset trig_any_o", 64'(bus.trig_any_o), 0);
    check("midreset scal_valid_o", 64'(bus.scal_valid_o), 0);
    check("midreset scal_dat_o", 64'(bus.scal_dat_o), 0);
    aresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.scal_valid_o) seen++;
    end
    check("no valid after midreset", 64'(seen), 0);
    check("latched cleared by reset", 64'(bus.scal_dat_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
